// File: rtl/qpp_interleaver_ctrl_pkg.sv
// qpp_interleaver_ctrl_pkg: shared FSM state type, default RAM sizing and 2-bit symbol type
package qpp_interleaver_ctrl_pkg;
    localparam int DEF_RAM_DEPTH = 2396;
    localparam int DEF_AW        = 12;
    typedef enum logic [1:0] {IDLE, LOAD, READ, DRAIN} state_t;
    typedef logic [1:0] sym_t;
endpackage

// File: rtl/qpp_interleaver_ctrl_addr_gen.sv
// qpp_addr_gen: multiplier-free QPP address recursion pi(i)=(f1*i+f2*i^2) mod k
//   init   : load pi=0, g=(f1+f2) mod k, d2=(2*f2) mod k
//   step   : advance pi and g by one index
//   k,f1,f2: block length and coefficients (f1,f2 < k assumed)
//   pi     : current address
module qpp_addr_gen
    import qpp_interleaver_ctrl_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init,
    input  logic          step,
    input  logic [AW-1:0] k,
    input  logic [AW-1:0] f1,
    input  logic [AW-1:0] f2,
    output logic [AW-1:0] pi
);
    logic [AW-1:0] g, d2;

    // both operands are already below m, so one conditional subtract suffices
    function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                              input logic [AW-1:0] m);
        logic [AW:0] s, d;
        s = {1'b0, a} + {1'b0, b};
        d = s - {1'b0, m};
        return (s >= {1'b0, m}) ? d[AW-1:0] : s[AW-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pi <= '0;
            g  <= '0;
            d2 <= '0;
        end else if (init) begin
            pi <= '0;
            g  <= mod_add(f1, f2, k);
            d2 <= mod_add(f2, f2, k);
        end else if (step) begin
            pi <= mod_add(pi, g, k);
            g  <= mod_add(g, d2, k);
        end
    end
endmodule

// File: rtl/qpp_interleaver_ctrl.sv
// qpp_interleaver_ctrl: loads a block in natural order into a 2-bit RAM, reads it back in QPP order
//   start, k_len, f1, f2          : block start pulse and parameters (sampled on start in IDLE)
//   in_valid, in_ready, in_data   : natural-order symbol input
//   ram_addr, ram_din, ram_we     : single RAM port, ram_dout valid one cycle after ram_addr
//   out_valid, out_data, out_last : interleaved output, no backpressure
//   busy, done, err               : status; err only exists with QPP_PARAM_CHECK_EN defined
// Optional build macro: QPP_PARAM_CHECK_EN rejects K=0, K>RAM_DEPTH, f1>=K, f2>=K.
module qpp_interleaver_ctrl
    import qpp_interleaver_ctrl_pkg::*;
#(
    parameter int RAM_DEPTH = DEF_RAM_DEPTH,
    parameter int AW        = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] k_len,
    input  logic [AW-1:0] f1,
    input  logic [AW-1:0] f2,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_data,
    output logic [AW-1:0] ram_addr,
    output logic [1:0]    ram_din,
    output logic          ram_we,
    input  logic [1:0]    ram_dout,
    output logic          out_valid,
    output logic [1:0]    out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(RAM_DEPTH);

    state_t        state, next_state;
    logic [AW-1:0] k_r, f1_r, f2_r, wr_cnt, rd_cnt, k_m1, pi;
    logic          init_q, bad, accept, wr_acc;

`ifdef QPP_PARAM_CHECK_EN
    assign bad = (k_len == '0) || ({1'b0, k_len} > DEPTH_W) || (f1 >= k_len) || (f2 >= k_len);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if ((state == IDLE) && start)
            err <= bad;
    end
`else
    assign bad = 1'b0;
    assign err = 1'b0;
`endif

    assign accept   = (state == IDLE) && start && !bad;
    assign k_m1     = k_r - AW'(1);
    assign in_ready = (state == LOAD);
    assign wr_acc   = in_ready && in_valid;
    // never write past the end of the attached RAM, even for an unchecked oversize K
    assign ram_we   = wr_acc && ({1'b0, wr_cnt} < DEPTH_W);
    assign ram_addr = (state == READ) ? pi : in_ready ? wr_cnt : '0;
    assign ram_din  = in_ready ? in_data : '0;
    assign out_data = out_valid ? sym_t'(ram_dout) : '0;
    assign busy     = (state != IDLE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (accept) next_state = LOAD;
            LOAD:  if (wr_acc && (wr_cnt == k_m1)) next_state = READ;
            READ:  if (rd_cnt == k_m1) next_state = DRAIN;
            DRAIN: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_r       <= '0;
            f1_r      <= '0;
            f2_r      <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            init_q    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            // generator seeds from the latched parameters one cycle after start
            init_q    <= accept;
            out_valid <= (state == READ);
            out_last  <= (state == READ) && (rd_cnt == k_m1);
            done      <= (state == DRAIN);
            if (accept) begin
                k_r    <= k_len;
                f1_r   <= f1;
                f2_r   <= f2;
                wr_cnt <= '0;
                rd_cnt <= '0;
            end
            if (wr_acc)
                wr_cnt <= wr_cnt + AW'(1);
            if (state == READ)
                rd_cnt <= rd_cnt + AW'(1);
        end
    end

    qpp_addr_gen #(.AW(AW)) u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .init (init_q),
        .step (state == READ),
        .k    (k_r),
        .f1   (f1_r),
        .f2   (f2_r),
        .pi   (pi)
    );
endmodule
